// File: rtl/ras_commit_restore_if.sv
// rtl/ras_commit_restore_if.sv - reload beat bundle between the commit RAS and the speculative RAS
//
// Carries one restore beat per valid/ready handshake.
//   RldValid  : beat valid (driven by the commit RAS)
//   RldReady  : speculative RAS accepts the beat
//   RldIndex  : beat number, 0 = oldest entry
//   RldDate   : entry data for this beat
//   RldCnt    : number of entries in this restore
//   RldLast   : final beat of the restore
//   RldParErr : stored parity disagrees with RldDate (RAS_RESTORE_PARITY_EN only)
// Modports: master = commit RAS (writer), slave = frontend RAS (reader).

interface ras_commit_restore_if #(
    parameter int RASPTRW = 4,
    parameter int ADDRW   = 32
);
    logic               RldValid;
    logic               RldReady;
    logic [RASPTRW-1:0] RldIndex;
    logic [ADDRW-1:0]   RldDate;
    logic [RASPTRW:0]   RldCnt;
    logic               RldLast;
`ifdef RAS_RESTORE_PARITY_EN
    logic               RldParErr;

    modport master (
        output RldValid, RldIndex, RldDate, RldCnt, RldLast, RldParErr,
        input  RldReady
    );

    modport slave (
        input  RldValid, RldIndex, RldDate, RldCnt, RldLast, RldParErr,
        output RldReady
    );
`else
    modport master (
        output RldValid, RldIndex, RldDate, RldCnt, RldLast,
        input  RldReady
    );

    modport slave (
        input  RldValid, RldIndex, RldDate, RldCnt, RldLast,
        output RldReady
    );
`endif
endinterface

// File: rtl/ras_commit_restore.sv
// rtl/ras_commit_restore.sv - commit-side return-address stack with flush-time restore streaming
//
// Keeps the architecturally correct RAS from retired calls/returns and, on a
// flush, streams it oldest-to-newest to the speculative RAS reload port.
// Optional feature macro: RAS_RESTORE_PARITY_EN (per-entry even parity and
// RldParErr on the reload interface).
//
// Ports:
//   Clk, Rest       : clock, synchronous active-high reset
//   CmtCallAble     : retired call, push CmtCallDate
//   CmtCallDate     : return address of the retired call
//   CmtRetAble      : retired return, pop
//   FlushReq        : redirect, start (or restart) a restore
//   rld             : reload beat interface (master side)
//   RldBusy         : restore in progress, frontend stalls
//   RldDone         : one-cycle pulse after the last beat is accepted
//   CmtDepth        : committed occupancy
//   CmtUnderflow    : one-cycle pulse after a pop on an empty stack

module ras_commit_restore #(
    parameter int RASDEEP = 16,
    parameter int RASPTRW = 4,
    parameter int ADDRW   = 32
) (
    input  logic                      Clk,
    input  logic                      Rest,
    input  logic                      CmtCallAble,
    input  logic [ADDRW-1:0]          CmtCallDate,
    input  logic                      CmtRetAble,
    input  logic                      FlushReq,
    ras_commit_restore_if.master      rld,
    output logic                      RldBusy,
    output logic                      RldDone,
    output logic [RASPTRW:0]          CmtDepth,
    output logic                      CmtUnderflow
);

`ifdef RAS_RESTORE_PARITY_EN
    localparam int MEMW = ADDRW + 1;
`else
    localparam int MEMW = ADDRW;
`endif

    localparam logic [RASPTRW-1:0] PTR_ONE  = 1;
    localparam logic [RASPTRW:0]   CNT_ONE  = 1;
    localparam logic [RASPTRW:0]   CNT_TWO  = 2;
    localparam logic [RASPTRW:0]   CNT_FULL = (RASPTRW+1)'(RASDEEP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SNAP,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic [MEMW-1:0]    mem [RASDEEP];

    logic [RASPTRW-1:0] top_ptr, top_nxt;
    logic [RASPTRW:0]   cnt, cnt_nxt;
    logic               we;
    logic [RASPTRW-1:0] waddr;
    logic [MEMW-1:0]    wdata;
    logic               underflow_nxt;
    logic               retire_en;

    logic [RASPTRW:0]   snap_cnt;
    logic [RASPTRW-1:0] base;
    logic [RASPTRW-1:0] k;
    logic [RASPTRW-1:0] snap_base;
    logic [RASPTRW-1:0] raddr;
    logic [MEMW-1:0]    rdata;
    logic               accept;

    assign CmtDepth  = cnt;
    assign retire_en = (state == ST_IDLE) || (state == ST_SNAP);
    assign accept    = rld.RldValid && rld.RldReady;

`ifdef RAS_RESTORE_PARITY_EN
    assign wdata = {^CmtCallDate, CmtCallDate};
`else
    assign wdata = CmtCallDate;
`endif

    // Retire update. A same-cycle call+return means the return retired first,
    // so the top entry is simply replaced.
    always_comb begin
        top_nxt       = top_ptr;
        cnt_nxt       = cnt;
        we            = 1'b0;
        waddr         = top_ptr + PTR_ONE;
        underflow_nxt = 1'b0;
        if (retire_en) begin
            if (CmtCallAble && CmtRetAble && (cnt != '0)) begin
                we    = 1'b1;
                waddr = top_ptr;
            end else if (CmtCallAble) begin
                we      = 1'b1;
                waddr   = top_ptr + PTR_ONE;
                top_nxt = top_ptr + PTR_ONE;
                cnt_nxt = (cnt == CNT_FULL) ? cnt : cnt + CNT_ONE;
            end else if (CmtRetAble) begin
                if (cnt != '0) begin
                    top_nxt = top_ptr - PTR_ONE;
                    cnt_nxt = cnt - CNT_ONE;
                end else begin
                    underflow_nxt = 1'b1;
                end
            end
        end
    end

    // Oldest entry of the post-update stack. With a full stack the low count
    // bits are zero, so this lands on top+1, which is the oldest slot.
    assign snap_base = top_nxt - cnt_nxt[RASPTRW-1:0] + PTR_ONE;

    // The first beat is read in SNAP, where a retire can still write this
    // cycle; forward the write so the beat sees the post-update entry.
    always_comb begin
        raddr = (state == ST_SNAP) ? snap_base : (base + k + PTR_ONE);
        rdata = mem[raddr];
        if (we && (waddr == raddr)) begin
            rdata = wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rest && we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rest) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A flush in SEND or DONE restarts the restore; a flush in SNAP is
    // already being served by the snapshot taken this cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (FlushReq) state_nxt = ST_SNAP;
            ST_SNAP: state_nxt = ST_SEND;
            ST_SEND: begin
                if (FlushReq) begin
                    state_nxt = ST_SNAP;
                end else if (accept && rld.RldLast) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = FlushReq ? ST_SNAP : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rest) begin
            top_ptr       <= '0;
            cnt           <= '0;
            CmtUnderflow  <= 1'b0;
            RldBusy       <= 1'b0;
            RldDone       <= 1'b0;
            snap_cnt      <= '0;
            base          <= '0;
            k             <= '0;
            rld.RldValid  <= 1'b0;
            rld.RldIndex  <= '0;
            rld.RldDate   <= '0;
            rld.RldCnt    <= '0;
            rld.RldLast   <= 1'b0;
`ifdef RAS_RESTORE_PARITY_EN
            rld.RldParErr <= 1'b0;
`endif
        end else begin
            top_ptr      <= top_nxt;
            cnt          <= cnt_nxt;
            CmtUnderflow <= underflow_nxt;
            RldBusy      <= (state_nxt != ST_IDLE);
            RldDone      <= (state_nxt == ST_DONE);

            case (state)
                ST_SNAP: begin
                    snap_cnt     <= cnt_nxt;
                    base         <= snap_base;
                    k            <= '0;
                    rld.RldValid <= 1'b1;
                    rld.RldIndex <= '0;
                    rld.RldCnt   <= cnt_nxt;
                    // An empty snapshot still produces one terminating beat.
                    rld.RldLast  <= (cnt_nxt <= CNT_ONE);
                    rld.RldDate  <= (cnt_nxt == '0) ? '0 : rdata[ADDRW-1:0];
`ifdef RAS_RESTORE_PARITY_EN
                    rld.RldParErr <= (cnt_nxt != '0) &&
                                     ((^rdata[ADDRW-1:0]) != rdata[ADDRW]);
`endif
                end
                ST_SEND: begin
                    if (FlushReq) begin
                        rld.RldValid <= 1'b0;
                        rld.RldIndex <= '0;
                        k            <= '0;
                    end else if (accept) begin
                        if (rld.RldLast) begin
                            rld.RldValid <= 1'b0;
                        end else begin
                            k            <= k + PTR_ONE;
                            rld.RldIndex <= k + PTR_ONE;
                            rld.RldDate  <= rdata[ADDRW-1:0];
                            // Next beat is last when k+1 == snap_cnt-1.
                            rld.RldLast  <= (({1'b0, k} + CNT_TWO) == snap_cnt);
`ifdef RAS_RESTORE_PARITY_EN
                            rld.RldParErr <= ((^rdata[ADDRW-1:0]) != rdata[ADDRW]);
`endif
                        end
                    end
                end
                default: begin
                    rld.RldValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ras_commit_restore.sv
// tb/tb_ras_commit_restore.sv - directed scoreboard bench for ras_commit_restore

module tb_ras_commit_restore;

    localparam int RASDEEP = 16;
    localparam int RASPTRW = 4;
    localparam int ADDRW   = 32;

    logic               Clk = 1'b0;
    logic               Rest;
    logic               CmtCallAble;
    logic [ADDRW-1:0]   CmtCallDate;
    logic               CmtRetAble;
    logic               FlushReq;
    logic               RldBusy;
    logic               RldDone;
    logic [RASPTRW:0]   CmtDepth;
    logic               CmtUnderflow;

    ras_commit_restore_if #(.RASPTRW(RASPTRW), .ADDRW(ADDRW)) rld_if ();

    ras_commit_restore #(
        .RASDEEP(RASDEEP),
        .RASPTRW(RASPTRW),
        .ADDRW  (ADDRW)
    ) dut (
        .Clk         (Clk),
        .Rest        (Rest),
        .CmtCallAble (CmtCallAble),
        .CmtCallDate (CmtCallDate),
        .CmtRetAble  (CmtRetAble),
        .FlushReq    (FlushReq),
        .rld         (rld_if),
        .RldBusy     (RldBusy),
        .RldDone     (RldDone),
        .CmtDepth    (CmtDepth),
        .CmtUnderflow(CmtUnderflow)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int             idx;
        logic [ADDRW-1:0] data;
        int             cnt;
        bit             last;
    } beat_t;

    beat_t            exp_q[$];
    logic [ADDRW-1:0] mstack[$];
    int total  = 0;
    int passed = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic retire(input bit call, input logic [ADDRW-1:0] d, input bit ret);
        bit uf;
        uf = ret && !call && (mstack.size() == 0);
        CmtCallAble = call;
        CmtCallDate = d;
        CmtRetAble  = ret;
        if (call && ret && mstack.size() > 0) begin
            mstack[mstack.size()-1] = d;
        end else if (call) begin
            mstack.push_back(d);
            if (mstack.size() > RASDEEP) void'(mstack.pop_front());
        end else if (ret && mstack.size() > 0) begin
            void'(mstack.pop_back());
        end
        step();
        CmtCallAble = 1'b0;
        CmtRetAble  = 1'b0;
        CmtCallDate = '0;
        chk("depth", CmtDepth, mstack.size());
        chk("underflow", CmtUnderflow, uf);
    endtask

    task automatic load_expect();
        beat_t b;
        exp_q.delete();
        if (mstack.size() == 0) begin
            b.idx = 0; b.data = '0; b.cnt = 0; b.last = 1'b1;
            exp_q.push_back(b);
        end else begin
            for (int i = 0; i < mstack.size(); i++) begin
                b.idx  = i;
                b.data = mstack[i];
                b.cnt  = mstack.size();
                b.last = (i == mstack.size() - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // Flush in cycle t: SNAP in t+1, first beat visible in t+2.
    task automatic flush();
        FlushReq = 1'b1;
        load_expect();
        step();
        FlushReq = 1'b0;
        chk("snap_valid", rld_if.RldValid, 1'b0);
        chk("snap_busy", RldBusy, 1'b1);
        chk("snap_done", RldDone, 1'b0);
        step();
        chk("first_valid", rld_if.RldValid, 1'b1);
    endtask

    task automatic collect(input int n, input logic [15:0] pat, input int patlen);
        int               got;
        int               c;
        bit               held;
        logic [RASPTRW-1:0] hidx;
        logic [ADDRW-1:0] hdata;
        beat_t            b;
        got  = 0;
        c    = 0;
        held = 1'b0;
        while (got < n && c < 200) begin
            rld_if.RldReady = (c < patlen) ? pat[c] : 1'b1;
            if (held) begin
                chk("hold_valid", rld_if.RldValid, 1'b1);
                chk("hold_index", rld_if.RldIndex, hidx);
                chk("hold_data", rld_if.RldDate, hdata);
                held = 1'b0;
            end
            if (rld_if.RldValid && rld_if.RldReady) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1'b1, 1'b0);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_index", rld_if.RldIndex, b.idx);
                    chk("beat_data", rld_if.RldDate, b.data);
                    chk("beat_cnt", rld_if.RldCnt, b.cnt);
                    chk("beat_last", rld_if.RldLast, b.last);
                end
                got++;
            end else if (rld_if.RldValid) begin
                held  = 1'b1;
                hidx  = rld_if.RldIndex;
                hdata = rld_if.RldDate;
            end
            step();
            c++;
        end
        rld_if.RldReady = 1'b0;
        chk("beats_accepted", got, n);
    endtask

    task automatic finish_check();
        chk("done_pulse", RldDone, 1'b1);
        chk("done_valid", rld_if.RldValid, 1'b0);
        chk("done_busy", RldBusy, 1'b1);
        step();
        chk("idle_done", RldDone, 1'b0);
        chk("idle_busy", RldBusy, 1'b0);
    endtask

    initial begin
        Rest            = 1'b1;
        CmtCallAble     = 1'b0;
        CmtCallDate     = '0;
        CmtRetAble      = 1'b0;
        FlushReq        = 1'b0;
        rld_if.RldReady = 1'b0;
        step();
        step();
        Rest = 1'b0;
        chk("rst_valid", rld_if.RldValid, 1'b0);
        chk("rst_busy", RldBusy, 1'b0);
        chk("rst_done", RldDone, 1'b0);
        chk("rst_depth", CmtDepth, 0);
        chk("rst_underflow", CmtUnderflow, 1'b0);
        chk("rst_last", rld_if.RldLast, 1'b0);
        chk("rst_cnt", rld_if.RldCnt, 0);

        // Three-entry restore, ready held high.
        retire(1'b1, 32'h1000, 1'b0);
        retire(1'b1, 32'h2000, 1'b0);
        retire(1'b1, 32'h3000, 1'b0);
        flush();
        collect(3, 16'hFFFF, 16);
        finish_check();

        // Empty stack restore.
        for (int i = 0; i < 3; i++) retire(1'b0, '0, 1'b1);
        flush();
        collect(1, 16'hFFFF, 16);
        finish_check();

        // Wrap: 18 pushes keep only the newest 16.
        for (int i = 0; i < 18; i++) retire(1'b1, 32'h100 + i, 1'b0);
        chk("full_depth", CmtDepth, 16);
        flush();
        collect(16, 16'hFFFF, 16);
        finish_check();
        for (int i = 0; i < 16; i++) retire(1'b0, '0, 1'b1);

        // Underflow, then push with simultaneous pop.
        retire(1'b0, '0, 1'b1);
        step();
        chk("underflow_clear", CmtUnderflow, 1'b0);
        retire(1'b1, 32'hA0, 1'b0);
        retire(1'b1, 32'hB0, 1'b1);
        flush();
        collect(1, 16'hFFFF, 16);
        finish_check();

        // Backpressure pattern 1,0,0,1,1.
        retire(1'b0, '0, 1'b1);
        retire(1'b1, 32'h11, 1'b0);
        retire(1'b1, 32'h22, 1'b0);
        retire(1'b1, 32'h33, 1'b0);
        flush();
        collect(3, 16'b1_1001, 5);
        finish_check();

        // Flush while beat 1 is on the bus restarts from index 0.
        flush();
        collect(1, 16'hFFFF, 16);
        chk("restart_beat1_index", rld_if.RldIndex, 1);
        FlushReq = 1'b1;
        load_expect();
        step();
        FlushReq = 1'b0;
        chk("restart_valid", rld_if.RldValid, 1'b0);
        chk("restart_busy", RldBusy, 1'b1);
        chk("restart_no_done", RldDone, 1'b0);
        step();
        collect(3, 16'hFFFF, 16);
        finish_check();

        // Reset in the middle of SEND.
        flush();
        step();
        chk("stall_valid", rld_if.RldValid, 1'b1);
        Rest = 1'b1;
        step();
        Rest = 1'b0;
        mstack.delete();
        chk("midrst_valid", rld_if.RldValid, 1'b0);
        chk("midrst_busy", RldBusy, 1'b0);
        chk("midrst_depth", CmtDepth, 0);
        flush();
        collect(1, 16'hFFFF, 16);
        finish_check();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ras_commit_restore.md
Name: ras_commit_restore

Overview:
- Commit-side return-address stack. Tracks retired calls and returns in an architecturally correct copy of the RAS.
- On a pipeline flush, streams that copy, bottom-to-top, to the speculative RAS reload port over a valid/ready beat interface.
- Sits between the retire stage and the frontend RAS. It is the writer for the RAS reload path; the frontend RAS is the reader.

Parameters:
- RASDEEP, 16, number of committed stack entries.
- RASPTRW, 4, pointer width (log2 RASDEEP).
- ADDRW, 32, return address width (matches `InstAddrBus).

Ports:
- Clk  in  1  clock.
- Rest  in  1  reset, synchronous, active-high.
- CmtCallAble  in  1  retired call; push CmtCallDate.
- CmtCallDate  in  ADDRW  return address of the retired call.
- CmtRetAble  in  1  retired return; pop.
- FlushReq  in  1  redirect; start restore sequence.
- RldValid  out  1  reload beat valid.
- RldReady  in  1  speculative RAS accepts beat.
- RldIndex  out  RASPTRW  beat number k, 0 = oldest entry.
- RldDate  out  ADDRW  entry data for beat k.
- RldCnt  out  RASPTRW+1  entries in this restore (snapshot); constant during a restore.
- RldLast  out  1  final beat of restore.
- RldBusy  out  1  restore in progress; frontend stalls.
- RldDone  out  1  one-cycle pulse after last beat accepted.
- CmtDepth  out  RASPTRW+1  current committed occupancy.
- CmtUnderflow  out  1  one-cycle pulse: pop on empty stack.

Behaviour:
- Reset: all outputs 0, TopPtr=0, Cnt=0, state IDLE. Storage is not cleared. Reset mid-restore aborts it the same cycle; no further beats.
- Storage is circular, RASDEEP x ADDRW. TopPtr points at the top entry. Cnt ranges 0..RASDEEP. CmtDepth=Cnt, registered.
- Push only: mem[TopPtr+1]<=data; TopPtr+=1 (mod RASDEEP); Cnt=min(Cnt+1,RASDEEP). When full, the oldest entry is silently overwritten.
- Pop only, Cnt>0: TopPtr-=1; Cnt-=1.
- Pop only, Cnt==0: no state change; CmtUnderflow=1 next cycle.
- Push and pop in the same cycle (return retires before call):
  - Cnt>0: mem[TopPtr]<=data; TopPtr and Cnt unchanged.
  - Cnt==0: behaves as push only, and no underflow pulse.
- Retire inputs are applied only in IDLE or SNAP. In SEND or DONE they are ignored; upstream guarantees none arrive while RldBusy=1.
- FSM states: IDLE, SNAP, SEND, DONE.
  - IDLE: on FlushReq, go to SNAP next cycle. Retire activity in the FlushReq cycle is applied first.
  - SNAP (1 cycle, RldBusy=1): latch SnapCnt=Cnt and Base=TopPtr-Cnt+1 (mod RASDEEP), using the post-update values; k=0; go to SEND.
  - SEND: RldValid=1; RldIndex=k; RldDate=mem[Base+k]; RldCnt=SnapCnt; RldLast=(k==SnapCnt-1).
    - Outputs are registered; once valid they stay stable until accepted.
    - On RldValid&RldReady: k+=1. If RldLast, go to DONE.
    - SnapCnt==0: exactly one beat with RldCnt=0, RldDate=0, RldIndex=0, RldLast=1.
  - DONE (1 cycle): RldDone=1, RldValid=0, RldBusy=1; then IDLE with RldBusy=0.
- RldBusy=1 in SNAP, SEND and DONE; 0 in IDLE.
- FlushReq during SEND or DONE restarts the restore:
  - next cycle RldValid=0 and state SNAP; k resets to 0;
  - no RldDone pulse for the aborted restore; the receiver discards partial beats.
- Latency: FlushReq at cycle t gives first RldValid at t+2. With RldReady held high, N entries complete at t+1+N, and RldDone is high in cycle t+2+N.
- Index arithmetic is modulo RASDEEP; RldCnt saturates at RASDEEP (16 fits in RASPTRW+1 bits).

Optional Feature:
- RAS_RESTORE_PARITY_EN defined:
  - each entry stores an extra even-parity bit computed on push;
  - adds output RldParErr (1 bit), valid with RldValid, =1 when recomputed parity of RldDate differs from the stored bit;
  - a RldParErr beat is still transferred normally.
- Not defined: no parity storage and no RldParErr port.

Test Plan:
- Reset, then push 0x1000, 0x2000, 0x3000; FlushReq with RldReady=1 -> three beats: idx0=0x1000, idx1=0x2000, idx2=0x3000 (RldLast), RldCnt=3, RldDone 1 cycle after the last accept, RldBusy low next cycle.
- Empty stack, FlushReq -> single beat RldCnt=0, RldDate=0, RldLast=1; then RldDone.
- Push 18 addresses 0x100..0x111, flush -> RldCnt=16, beats 0x102..0x111 in order; CmtDepth=16.
- Pop on empty -> CmtUnderflow pulse, CmtDepth stays 0. Push 0xA0, then push 0xB0 with a simultaneous pop -> CmtDepth=1; flush gives one beat 0xB0.
- 3-entry restore with RldReady toggling 1,0,0,1,1 -> RldDate/RldIndex held stable while not ready; exactly 3 accepted beats in order. FlushReq on beat 1 -> restart from idx0, no RldDone for the aborted pass.
- Assert Rest mid-SEND -> RldValid, RldBusy, CmtDepth all 0 the next cycle; a new flush yields one empty beat.
